// File: rtl/alu_cmd_engine.sv
`timescale 1ns/1ps
// alu_cmd_engine
//   Byte-stream command processor sitting between a UART receiver and a UART
//   transmitter. Parses [opcode][rsvd][len_lo][len_hi][payload] packets
//   (len counts the whole packet including the 4-byte header) and answers
//   with an echo of the payload, a sum, or a product of OB-byte little-endian
//   operands (OB = OPERAND_WIDTH/8).
//
//   Optional feature macro: ALU_ERR_RESP_EN
//     defined   : a malformed packet produces a single 0xEE response byte
//     undefined : malformed packets are silently drained
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   s_axis_tdata   input byte
//   s_axis_tvalid  input byte valid
//   s_axis_tready  engine accepts input byte
//   m_axis_tdata   output byte (registered)
//   m_axis_tvalid  output byte valid (registered)
//   m_axis_tready  downstream accepts output byte
module alu_cmd_engine #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OPERAND_WIDTH = 32,
  parameter logic [7:0]  OP_ECHO       = 8'hEC,
  parameter logic [7:0]  OP_ADD        = 8'hA5,
  parameter logic [7:0]  OP_MUL        = 8'h6E
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned OW = OPERAND_WIDTH;
  localparam int unsigned OB = OPERAND_WIDTH / 8;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = $clog2(OB + 1);
  localparam int unsigned MW = (OW > 1) ? $clog2(OW) : 1;

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("alu_cmd_engine: DATA_WIDTH must be 8");
  end
  if ((OPERAND_WIDTH == 0) || ((OPERAND_WIDTH % 8) != 0)) begin : g_bad_operand_width
    $error("alu_cmd_engine: OPERAND_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [3:0] {
    S_OPCODE    = 4'd0,
    S_RSVD      = 4'd1,
    S_LEN_LO    = 4'd2,
    S_LEN_HI    = 4'd3,
    S_ECHO_PASS = 4'd4,
    S_COLLECT   = 4'd5,
    S_MUL_BUSY  = 4'd6,
    S_SEND      = 4'd7,
    S_DRAIN     = 4'd8
  } state_e;

  // Where a malformed packet goes once it has been fully consumed
`ifdef ALU_ERR_RESP_EN
  localparam state_e ERR_EXIT = S_SEND;
`else
  localparam state_e ERR_EXIT = S_OPCODE;
`endif

  state_e state_q, state_d;

  logic [7:0]    opcode_q;
  logic [7:0]    len_lo_q;
  logic [LW-1:0] rem_q;        // payload bytes still to be consumed
  logic [CW-1:0] byte_idx_q;   // byte position within the current operand
  logic [CW-1:0] send_cnt_q;   // response bytes already loaded into the output register
  logic [CW-1:0] send_num_q;   // response length in bytes
  logic [MW-1:0] mul_cnt_q;
  logic [OW-1:0] operand_q;    // operand shift-in register, multiplier during MUL_BUSY
  logic [OW-1:0] acc_q;        // accumulator / product / response shift-out register
  logic [OW-1:0] mcand_q;      // shifted multiplicand
  logic          first_q;      // next completed operand is the first of the packet
  logic [DW-1:0] m_tdata_q;
  logic          m_tvalid_q;

  logic          s_fire_c;
  logic          m_fire_c;
  logic [LW:0]   len_c;
  logic [LW-1:0] rem_c;
  logic          len_short_c;
  logic          rem_zero_c;
  logic          rem_pos_c;
  logic          op_echo_c;
  logic          op_arith_c;
  logic          misaligned_c;
  logic          malformed_c;
  logic          last_payload_c;
  logic          opnd_last_byte_c;
  logic [OW-1:0] opnd_c;

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;

  assign s_fire_c = s_axis_tvalid && s_axis_tready;
  assign m_fire_c = m_tvalid_q && m_axis_tready;

  // Header decode, evaluated while the len_hi byte is on the input
  assign len_c        = {1'b0, s_axis_tdata, len_lo_q};
  assign rem_c        = LW'(len_c - (LW + 1)'(4));
  assign len_short_c  = (len_c < (LW + 1)'(4));
  assign rem_zero_c   = (len_c == (LW + 1)'(4));
  assign rem_pos_c    = (len_c > (LW + 1)'(4));
  assign op_echo_c    = (opcode_q == OP_ECHO);
  assign op_arith_c   = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
  assign misaligned_c = ((rem_c % LW'(OB)) != '0);
  assign malformed_c  = len_short_c
                     || (!op_echo_c && !op_arith_c)
                     || (op_arith_c && (rem_zero_c || misaligned_c));

  assign last_payload_c   = (rem_q == LW'(1));
  assign opnd_last_byte_c = (byte_idx_q == CW'(OB - 1));

  // Operand value including the byte currently on the input (little-endian)
  assign opnd_c = (operand_q >> 8) | (OW'(s_axis_tdata) << (OW - 8));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_OPCODE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OPCODE: if (s_fire_c) state_d = S_RSVD;
      S_RSVD:   if (s_fire_c) state_d = S_LEN_LO;
      S_LEN_LO: if (s_fire_c) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (s_fire_c) begin
          if (malformed_c) begin
            state_d = rem_pos_c ? S_DRAIN : ERR_EXIT;
          end else if (rem_zero_c) begin
            state_d = S_OPCODE;  // empty echo
          end else if (op_echo_c) begin
            state_d = S_ECHO_PASS;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_ECHO_PASS: if (s_fire_c && last_payload_c) state_d = S_OPCODE;
      S_COLLECT: begin
        if (s_fire_c && opnd_last_byte_c) begin
          if (opcode_q == OP_MUL) begin
            state_d = S_MUL_BUSY;
          end else if (last_payload_c) begin
            state_d = S_SEND;
          end
        end
      end
      S_MUL_BUSY: begin
        if (mul_cnt_q == MW'(OW - 1)) begin
          state_d = (rem_q == '0) ? S_SEND : S_COLLECT;
        end
      end
      S_SEND: if (m_fire_c && (send_cnt_q == send_num_q)) state_d = S_OPCODE;
      S_DRAIN: if (s_fire_c && last_payload_c) state_d = ERR_EXIT;
      default: state_d = S_OPCODE;
    endcase
  end

  // Input ready; a pending output byte only throttles echo
  always_comb begin
    s_axis_tready = 1'b0;
    if (rst_ni) begin
      case (state_q)
        S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI,
        S_COLLECT, S_DRAIN: s_axis_tready = 1'b1;
        S_ECHO_PASS:        s_axis_tready = !m_tvalid_q || m_axis_tready;
        default:            s_axis_tready = 1'b0;
      endcase
    end
  end

  // Datapath: header capture, operand collection, shift-add multiplier, output register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      opcode_q   <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      byte_idx_q <= '0;
      send_cnt_q <= '0;
      send_num_q <= '0;
      mul_cnt_q  <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      first_q    <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      if (m_fire_c) begin
        m_tvalid_q <= 1'b0;
      end
      case (state_q)
        S_OPCODE: if (s_fire_c) opcode_q <= s_axis_tdata;
        S_LEN_LO: if (s_fire_c) len_lo_q <= s_axis_tdata;
        S_LEN_HI: begin
          if (s_fire_c) begin
            rem_q      <= rem_pos_c ? rem_c : '0;
            byte_idx_q <= '0;
            first_q    <= 1'b1;
            send_cnt_q <= '0;
            send_num_q <= CW'(OB);
`ifdef ALU_ERR_RESP_EN
            if (malformed_c && !rem_pos_c) begin
              acc_q      <= OW'(8'hEE);
              send_num_q <= CW'(1);
            end
`endif
          end
        end
        S_ECHO_PASS: begin
          if (s_fire_c) begin
            m_tdata_q  <= s_axis_tdata;
            m_tvalid_q <= 1'b1;
            rem_q      <= rem_q - LW'(1);
          end
        end
        S_COLLECT: begin
          if (s_fire_c) begin
            rem_q      <= rem_q - LW'(1);
            operand_q  <= opnd_c;
            byte_idx_q <= byte_idx_q + CW'(1);
            if (opnd_last_byte_c) begin
              byte_idx_q <= '0;
              first_q    <= 1'b0;
              if (opcode_q == OP_MUL) begin
                // First operand multiplies by 1 so every operand takes one busy pass
                mcand_q   <= first_q ? OW'(1) : acc_q;
                acc_q     <= '0;
                mul_cnt_q <= '0;
              end else begin
                acc_q <= first_q ? opnd_c : acc_q + opnd_c;
              end
            end
          end
        end
        S_MUL_BUSY: begin
          if (operand_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q   <= mcand_q << 1;
          operand_q <= operand_q >> 1;
          mul_cnt_q <= mul_cnt_q + MW'(1);
        end
        S_SEND: begin
          // Load the next response byte whenever the output register is free
          if ((send_cnt_q != send_num_q) && (!m_tvalid_q || m_axis_tready)) begin
            m_tdata_q  <= acc_q[DW-1:0];
            m_tvalid_q <= 1'b1;
            acc_q      <= acc_q >> DW;
            send_cnt_q <= send_cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (s_fire_c) begin
            rem_q <= rem_q - LW'(1);
`ifdef ALU_ERR_RESP_EN
            if (last_payload_c) begin
              acc_q      <= OW'(8'hEE);
              send_num_q <= CW'(1);
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_engine.sv
`timescale 1ns/1ps
// Self-checking bench for alu_cmd_engine: a table of whole packets with
// hand-computed responses, plus directed sequences for multiply timing,
// output backpressure, echo stall and reset in the middle of a packet.
module tb_alu_cmd_engine;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] out_q [$];

`ifdef ALU_ERR_RESP_EN
  localparam int ERR_N = 1;
`else
  localparam int ERR_N = 0;
`endif

  typedef struct {
    string        name;
    int           n_in;
    logic [127:0] din;   // first byte in the most significant used position
    int           n_out;
    logic [63:0]  dout;
  } vec_t;

  vec_t vecs [$];

  alu_cmd_engine dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: a byte transfers at the next rising edge if valid && ready
  always @(negedge clk) begin
    #1;
    if (rst_n && m_tvalid && m_tready) out_q.push_back(m_tdata);
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one byte; returns at the falling edge after it was accepted
  task automatic put_w(input logic [7:0] b, output int waits);
    waits    = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && waits < 500) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk("s_tready_wait", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    int w;
    put_w(b, w);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
  endtask

  function automatic void add_vec(input string nm, input int n_in, input logic [127:0] din,
                                  input int n_out, input logic [63:0] dout);
    vec_t v;
    v.name  = nm;
    v.n_in  = n_in;
    v.din   = din;
    v.n_out = n_out;
    v.dout  = dout;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string nm, input int n, input logic [63:0] exp);
    logic [63:0] e;
    e = exp;
    chk($sformatf("%s.count", nm), 32'(out_q.size()), 32'(n));
    for (int j = 0; j < n && j < out_q.size(); j++) begin
      chk($sformatf("%s.byte%0d", nm, j), 32'(out_q[j]), 32'(e[8*(n-1-j) +: 8]));
    end
  endtask

  initial begin
    int          w;
    int          cnt;
    logic [127:0] d;

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;

    add_vec("echo2",       6, 128'({8'hEC,8'h00,8'h06,8'h00,8'h11,8'h22}), 2, 64'({8'h11,8'h22}));
    add_vec("echo0",       4, 128'({8'hEC,8'h00,8'h04,8'h00}), 0, 64'h0);
    add_vec("add_wrap",   12, 128'({8'hA5,8'h00,8'h0C,8'h00,8'h01,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'hFF}),
            4, 64'({8'h00,8'h00,8'h00,8'h00}));
    add_vec("mul",        12, 128'({8'h6E,8'h00,8'h0C,8'h00,8'h03,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00}),
            4, 64'({8'h0F,8'h00,8'h00,8'h00}));
    add_vec("bad_op",      6, 128'({8'h11,8'h00,8'h06,8'h00,8'hAA,8'hBB}), ERR_N, 64'h00EE);
    add_vec("add_single",  8, 128'({8'hA5,8'h00,8'h08,8'h00,8'h02,8'h00,8'h00,8'h00}),
            4, 64'({8'h02,8'h00,8'h00,8'h00}));
    add_vec("add_misalign",7, 128'({8'hA5,8'h00,8'h07,8'h00,8'h01,8'h02,8'h03}), ERR_N, 64'h00EE);
    add_vec("add_single2", 8, 128'({8'hA5,8'h00,8'h08,8'h00,8'h02,8'h00,8'h00,8'h00}),
            4, 64'({8'h02,8'h00,8'h00,8'h00}));
    add_vec("add3",       16, 128'({8'hA5,8'h00,8'h10,8'h00,8'h10,8'h00,8'h00,8'h00,
                                    8'h20,8'h00,8'h00,8'h00,8'h30,8'h00,8'h00,8'h80}),
            4, 64'({8'h60,8'h00,8'h00,8'h80}));
    add_vec("mul_neg",    12, 128'({8'h6E,8'h00,8'h0C,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}),
            4, 64'({8'h01,8'h00,8'h00,8'h00}));
    add_vec("mul_single",  8, 128'({8'h6E,8'h00,8'h08,8'h00,8'h78,8'h56,8'h34,8'h12}),
            4, 64'({8'h78,8'h56,8'h34,8'h12}));
    add_vec("add_len4",    4, 128'({8'hA5,8'h00,8'h04,8'h00}), ERR_N, 64'h00EE);
    add_vec("len_short",   4, 128'({8'hEC,8'h00,8'h02,8'h00}), ERR_N, 64'h00EE);
    add_vec("mul3",       16, 128'({8'h6E,8'h00,8'h10,8'h00,8'h02,8'h00,8'h00,8'h00,
                                    8'h03,8'h00,8'h00,8'h00,8'h07,8'h00,8'h00,8'h00}),
            4, 64'({8'h2A,8'h00,8'h00,8'h00}));
    add_vec("echo1",       5, 128'({8'hEC,8'h00,8'h05,8'h00,8'h7E}), 1, 64'h007E);
    add_vec("add_carry",  12, 128'({8'hA5,8'h00,8'h0C,8'h00,8'h78,8'h56,8'h34,8'h12,8'h11,8'h11,8'h11,8'h11}),
            4, 64'({8'h89,8'h67,8'h45,8'h23}));
    add_vec("mul_shift",  12, 128'({8'h6E,8'h00,8'h0C,8'h00,8'h45,8'h23,8'h01,8'h00,8'h00,8'h01,8'h00,8'h00}),
            4, 64'({8'h00,8'h45,8'h23,8'h01}));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.s_tready", 32'(s_tready), 32'd0);
    chk("rst.m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst.m_tdata",  32'(m_tdata),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst.s_tready", 32'(s_tready), 32'd1);
    @(negedge clk);

    // Table-driven packets
    for (int i = 0; i < vecs.size(); i++) begin
      out_q.delete();
      d = vecs[i].din;
      for (int j = 0; j < vecs[i].n_in; j++) begin
        put(d[8*(vecs[i].n_in-1-j) +: 8]);
      end
      wait_out(vecs[i].n_out);
      check_out(vecs[i].name, vecs[i].n_out, vecs[i].dout);
    end

    // Multiply timing: busy for exactly OPERAND_WIDTH cycles per operand
    out_q.delete();
    put(8'h6E); put(8'h00); put(8'h0C); put(8'h00);
    put(8'h03); put(8'h00); put(8'h00); put(8'h00);
    put_w(8'h05, w);
    chk("mul_timing.busy_cycles", 32'(w), 32'd32);
    put(8'h00); put(8'h00); put(8'h00);
    cnt = 0;
    while (!m_tvalid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("mul_timing.first_out_latency", 32'(cnt), 32'd33);
    wait_out(4);
    check_out("mul_timing", 4, 64'({8'h0F,8'h00,8'h00,8'h00}));

    // Backpressure mid-SEND: second byte held stable for 10 cycles
    out_q.delete();
    m_tready = 1'b0;
    put(8'hA5); put(8'h00); put(8'h0C); put(8'h00);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    put(8'h11); put(8'h11); put(8'h11); put(8'h11);
    cnt = 0;
    while (!m_tvalid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp.first_byte", 32'(m_tdata), 32'h89);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp.hold_valid%0d", k), 32'(m_tvalid), 32'd1);
      chk($sformatf("bp.hold_data%0d", k),  32'(m_tdata),  32'h67);
    end
    m_tready = 1'b1;
    wait_out(4);
    check_out("bp", 4, 64'({8'h89,8'h67,8'h45,8'h23}));

    // Echo stalls while the output register is full
    out_q.delete();
    m_tready = 1'b0;
    put(8'hEC); put(8'h00); put(8'h06); put(8'h00); put(8'h11);
    fork
      put(8'h22);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("echo_stall.s_tready%0d", k), 32'(s_tready), 32'd0);
          chk($sformatf("echo_stall.m_tdata%0d", k),  32'(m_tdata),  32'h11);
        end
        m_tready = 1'b1;
      end
    join
    wait_out(2);
    check_out("echo_stall", 2, 64'({8'h11,8'h22}));

    // Reset in the middle of COLLECT discards the packet
    out_q.delete();
    put(8'hA5); put(8'h00); put(8'h0C); put(8'h00); put(8'h01); put(8'h02);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    chk("mid_rst.m_tvalid", 32'(m_tvalid), 32'd0);
    rst_n = 1'b1;
    put(8'hEC); put(8'h00); put(8'h05); put(8'h00); put(8'h7E);
    wait_out(1);
    check_out("mid_rst", 1, 64'h007E);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
